// File: rtl/util_pkg.sv
// Shared genrams helpers: ceil-log2 sizing, FIFO mode constants and the
// FIFO status flag bundle used by the controller and the top level.
package util_pkg;

    localparam int c_fifo_standard   = 0;
    localparam int c_fifo_show_ahead = 1;

    // Returns ceil(log2(n)), never less than 1 so a signal is at least one bit wide.
    function automatic int clogb2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t c_flags_reset = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/gc_sync_fifo_ctrl.sv
// FIFO bookkeeping: wrap-at-any-depth pointers, occupancy count, registered
// level flags and sticky overflow/underflow detection.
module gc_sync_fifo_ctrl
    import util_pkg::*;
#(
    parameter int g_size                   = 16,
    parameter int g_almost_empty_threshold = 2,
    parameter int g_almost_full_threshold  = 14
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          we_i,
    input  logic                          rd_i,
    output logic                          wr_acc,
    output logic                          rd_acc,
    output logic [clogb2(g_size)-1:0]     wr_ptr,
    output logic [clogb2(g_size)-1:0]     rd_ptr,
    output logic [clogb2(g_size+1)-1:0]   count,
    output fifo_flags_t                   flags
);

    localparam int c_ptr_w = clogb2(g_size);
    localparam int c_cnt_w = clogb2(g_size + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(g_size - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(g_size);
    localparam logic [c_cnt_w-1:0] c_ae       = c_cnt_w'(g_almost_empty_threshold);
    localparam logic [c_cnt_w-1:0] c_af       = c_cnt_w'(g_almost_full_threshold);

    if (g_size < 2) begin : g_bad_size
        $error("gc_sync_fifo_ctrl: g_size must be at least 2");
    end
    if (g_almost_empty_threshold < 0 || g_almost_empty_threshold > g_size) begin : g_bad_ae
        $error("gc_sync_fifo_ctrl: almost-empty threshold outside 0..g_size");
    end
    if (g_almost_full_threshold < 0 || g_almost_full_threshold > g_size) begin : g_bad_af
        $error("gc_sync_fifo_ctrl: almost-full threshold outside 0..g_size");
    end

    logic [c_ptr_w-1:0] wr_ptr_nxt;
    logic [c_ptr_w-1:0] rd_ptr_nxt;
    logic [c_cnt_w-1:0] count_nxt;

    // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
    always_comb begin
        rd_acc     = rd_i && !flags.empty;
        wr_acc     = we_i && (!flags.full || rd_acc);
        wr_ptr_nxt = (wr_ptr == c_ptr_last) ? '0 : wr_ptr + c_ptr_w'(1);
        rd_ptr_nxt = (rd_ptr == c_ptr_last) ? '0 : rd_ptr + c_ptr_w'(1);
        count_nxt  = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + c_cnt_w'(1);
            2'b01:   count_nxt = count - c_cnt_w'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= c_flags_reset;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= c_flags_reset;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr_nxt;
            if (rd_acc) rd_ptr <= rd_ptr_nxt;
            count              <= count_nxt;
            flags.empty        <= (count_nxt == '0);
            flags.full         <= (count_nxt == c_cnt_full);
            flags.almost_empty <= (count_nxt <= c_ae);
            flags.almost_full  <= (count_nxt >= c_af);
            flags.overflow     <= flags.overflow  || (we_i && !wr_acc);
            flags.underflow    <= flags.underflow || (rd_i && !rd_acc);
        end
    end

endmodule

// File: rtl/gc_sync_fifo_ext.sv
// Single-clock FIFO of any depth >= 2 with standard or show-ahead read,
// programmable almost-full/empty levels, occupancy count and sticky errors.
module gc_sync_fifo_ext
    import util_pkg::*;
#(
    parameter int g_data_width             = 32,
    parameter int g_size                   = 16,
    parameter int g_show_ahead             = 0,
    parameter int g_almost_empty_threshold = 2,
    parameter int g_almost_full_threshold  = 14
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic [g_data_width-1:0]       d_i,
    input  logic                          we_i,
    input  logic                          rd_i,
    output logic [g_data_width-1:0]       q_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          almost_empty_o,
    output logic                          almost_full_o,
    output logic [clogb2(g_size+1)-1:0]   count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int c_ptr_w = clogb2(g_size);

    if (g_show_ahead != c_fifo_standard && g_show_ahead != c_fifo_show_ahead) begin : g_bad_mode
        $error("gc_sync_fifo_ext: g_show_ahead must be 0 or 1");
    end

    // Handshake: we_i and rd_i are single-cycle requests with no stall. A write is
    // taken when not full (or when a read is taken in the same cycle), a read is
    // taken when not empty; anything else is dropped and latches overflow/underflow.
    logic               wr_acc;
    logic               rd_acc;
    logic [c_ptr_w-1:0] wr_ptr;
    logic [c_ptr_w-1:0] rd_ptr;
    fifo_flags_t        flags;

    logic [g_data_width-1:0] mem [g_size];

    gc_sync_fifo_ctrl #(
        .g_size                   (g_size),
        .g_almost_empty_threshold (g_almost_empty_threshold),
        .g_almost_full_threshold  (g_almost_full_threshold)
    ) u_ctrl (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .we_i   (we_i),
        .rd_i   (rd_i),
        .wr_acc (wr_acc),
        .rd_acc (rd_acc),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count_o),
        .flags  (flags)
    );

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr] <= d_i;
    end

    if (g_show_ahead == c_fifo_show_ahead) begin : g_show_ahead_path
        // Head word is driven straight from the array; forced to zero while empty.
        assign q_o = flags.empty ? '0 : mem[rd_ptr];
    end else begin : g_standard_path
        logic [g_data_width-1:0] q_reg;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                q_reg <= '0;
            end else if (clr_i) begin
                q_reg <= '0;
            end else if (rd_acc) begin
                q_reg <= mem[rd_ptr];
            end
        end
        assign q_o = q_reg;
    end

    assign empty_o        = flags.empty;
    assign full_o         = flags.full;
    assign almost_empty_o = flags.almost_empty;
    assign almost_full_o  = flags.almost_full;
    assign overflow_o     = flags.overflow;
    assign underflow_o    = flags.underflow;

endmodule

// File: tb/tb_gc_sync_fifo_ext.sv
// Bench for gc_sync_fifo_ext: three instances (depth 5 standard, depth 5
// show-ahead, depth 16 standard) share one stimulus stream and a queue model.
module tb_gc_sync_fifo_ext;

    localparam int W = 8;

    // ---------------- clock / reset / stimulus signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         we  = 1'b0;
    logic         rd  = 1'b0;
    logic [W-1:0] d   = '0;

    always #5 clk = ~clk;

    logic [W-1:0] q_a, q_b, q_c;
    logic         empty_a, full_a, aempty_a, afull_a, ovf_a, unf_a;
    logic         empty_b, full_b, aempty_b, afull_b, ovf_b, unf_b;
    logic         empty_c, full_c, aempty_c, afull_c, ovf_c, unf_c;
    logic [2:0]   count_a, count_b;
    logic [4:0]   count_c;

    gc_sync_fifo_ext #(.g_data_width(W), .g_size(5), .g_show_ahead(0),
                       .g_almost_empty_threshold(1), .g_almost_full_threshold(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .d_i(d), .we_i(we), .rd_i(rd),
        .q_o(q_a), .empty_o(empty_a), .full_o(full_a), .almost_empty_o(aempty_a),
        .almost_full_o(afull_a), .count_o(count_a), .overflow_o(ovf_a), .underflow_o(unf_a));

    gc_sync_fifo_ext #(.g_data_width(W), .g_size(5), .g_show_ahead(1),
                       .g_almost_empty_threshold(1), .g_almost_full_threshold(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .d_i(d), .we_i(we), .rd_i(rd),
        .q_o(q_b), .empty_o(empty_b), .full_o(full_b), .almost_empty_o(aempty_b),
        .almost_full_o(afull_b), .count_o(count_b), .overflow_o(ovf_b), .underflow_o(unf_b));

    gc_sync_fifo_ext #(.g_data_width(W), .g_size(16), .g_show_ahead(0),
                       .g_almost_empty_threshold(2), .g_almost_full_threshold(14)) dut_c (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .d_i(d), .we_i(we), .rd_i(rd),
        .q_o(q_c), .empty_o(empty_c), .full_o(full_c), .almost_empty_o(aempty_c),
        .almost_full_o(afull_c), .count_o(count_c), .overflow_o(ovf_c), .underflow_o(unf_c));

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [W-1:0] exp_q5[$];
    logic [W-1:0] exp_q16[$];
    logic [W-1:0] qstd5  = '0;
    logic [W-1:0] qstd16 = '0;
    bit ov5 = 0, un5 = 0, ov16 = 0, un16 = 0;

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural FIFO: clear wins, reads pop before writes push.
    task automatic model_step(input bit w, input bit r, input logic [W-1:0] dv, input bit c);
        bit rok, wok;
        if (c) begin
            exp_q5.delete();
            exp_q16.delete();
            qstd5 = '0; qstd16 = '0;
            ov5 = 0; un5 = 0; ov16 = 0; un16 = 0;
            return;
        end
        rok = r && (exp_q5.size() > 0);
        wok = w && (exp_q5.size() < 5 || rok);
        if (r && !rok) un5 = 1;
        if (w && !wok) ov5 = 1;
        if (rok) qstd5 = exp_q5.pop_front();
        if (wok) exp_q5.push_back(dv);

        rok = r && (exp_q16.size() > 0);
        wok = w && (exp_q16.size() < 16 || rok);
        if (r && !rok) un16 = 1;
        if (w && !wok) ov16 = 1;
        if (rok) qstd16 = exp_q16.pop_front();
        if (wok) exp_q16.push_back(dv);
    endtask

    task automatic check_flags(input string tag, input int sz, input int n, input int aet,
                               input int aft, input bit ov_e, input bit un_e,
                               input logic [31:0] cnt, input logic e, input logic f,
                               input logic ae, input logic af, input logic ov, input logic un);
        chkv({tag, ".count"}, cnt, 32'(sz));
        chkb({tag, ".empty"}, e, sz == 0);
        chkb({tag, ".full"}, f, sz == n);
        chkb({tag, ".aempty"}, ae, sz <= aet);
        chkb({tag, ".afull"}, af, sz >= aft);
        chkb({tag, ".overflow"}, ov, ov_e);
        chkb({tag, ".underflow"}, un, un_e);
    endtask

    task automatic check_all(input string tag);
        check_flags({tag, "/a"}, exp_q5.size(), 5, 1, 4, ov5, un5, 32'(count_a),
                    empty_a, full_a, aempty_a, afull_a, ovf_a, unf_a);
        chkv({tag, "/a.q"}, 32'(q_a), 32'(qstd5));
        check_flags({tag, "/b"}, exp_q5.size(), 5, 1, 4, ov5, un5, 32'(count_b),
                    empty_b, full_b, aempty_b, afull_b, ovf_b, unf_b);
        if (exp_q5.size() > 0) chkv({tag, "/b.q"}, 32'(q_b), 32'(exp_q5[0]));
        check_flags({tag, "/c"}, exp_q16.size(), 16, 2, 14, ov16, un16, 32'(count_c),
                    empty_c, full_c, aempty_c, afull_c, ovf_c, unf_c);
        chkv({tag, "/c.q"}, 32'(q_c), 32'(qstd16));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let the rising edge happen, check at the next fall.
    task automatic step(input bit w, input bit r, input logic [W-1:0] dv, input bit c,
                        input string tag);
        we = w; rd = r; d = dv; clr = c;
        @(posedge clk);
        model_step(w, r, dv, c);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    logic [W-1:0] tail_exp [5];

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        model_step(0, 0, '0, 1);
        check_all("reset");
        chkv("reset.q_b", 32'(q_b), 32'h0);
        rst = 1'b0;
        step(0, 0, '0, 0, "idle");

        // fill and drain a depth-5 FIFO three times so pointers wrap 4 -> 0
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 1; i <= 5; i++) step(1, 0, W'(i), 0, "fill5");
            chkb("fill5.full", full_a, 1'b1);
            chkv("fill5.count", 32'(count_a), 32'd5);
            for (int i = 1; i <= 5; i++) begin
                step(0, 1, '0, 0, "drain5");
                chkv("drain5.q", 32'(q_a), 32'(i));
            end
            chkb("drain5.empty", empty_a, 1'b1);
        end

        // simultaneous write+read while full
        for (int i = 0; i < 5; i++) step(1, 0, W'(8'h11 + i), 0, "refill");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, W'(8'hA0 + i), 0, "rw_full");
            chkv("rw_full.count", 32'(count_a), 32'd5);
            chkb("rw_full.overflow", ovf_a, 1'b0);
        end
        tail_exp = '{8'h15, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 5; i++) begin
            step(0, 1, '0, 0, "rw_drain");
            chkv("rw_drain.q", 32'(q_a), 32'(tail_exp[i]));
        end

        // sticky overflow / underflow, then clear (clear beats a same-cycle write)
        for (int i = 0; i < 5; i++) step(1, 0, W'(8'h30 + i), 0, "err_fill");
        step(1, 0, 8'h99, 0, "overflow");
        chkb("overflow.set", ovf_a, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 1, '0, 0, "err_drain");
        step(0, 1, '0, 0, "underflow");
        chkb("underflow.set", unf_a, 1'b1);
        step(0, 0, '0, 0, "sticky");
        chkb("sticky.overflow", ovf_a, 1'b1);
        chkb("sticky.underflow", unf_a, 1'b1);
        step(1, 0, 8'h77, 1, "clr");
        chkb("clr.overflow", ovf_a, 1'b0);
        chkb("clr.underflow", unf_a, 1'b0);
        chkv("clr.count", 32'(count_a), 32'd0);
        chkb("clr.empty", empty_a, 1'b1);

        // show-ahead vs standard read latency
        step(1, 0, 8'h55, 0, "sa_write");
        chkv("sa_write.q_b", 32'(q_b), 32'h55);
        chkv("sa_write.q_a_hold", 32'(q_a), 32'h00);
        step(0, 0, '0, 0, "sa_idle");
        step(0, 1, '0, 0, "std_read");
        chkv("std_read.q_a", 32'(q_a), 32'h55);
        step(1, 1, 8'h66, 0, "rw_empty");
        chkv("rw_empty.q_b", 32'(q_b), 32'h66);
        chkb("rw_empty.underflow", unf_a, 1'b1);
        step(0, 1, '0, 0, "rw_empty_drain");
        step(0, 0, '0, 1, "clr2");

        // threshold edges on the depth-16 instance
        for (int i = 1; i <= 14; i++) begin
            step(1, 0, W'(8'h40 + i), 0, "thr_fill");
            if (i == 2)  chkb("thr.ae_at2", aempty_c, 1'b1);
            if (i == 3)  chkb("thr.ae_at3", aempty_c, 1'b0);
            if (i == 13) chkb("thr.af_at13", afull_c, 1'b0);
            if (i == 14) chkb("thr.af_at14", afull_c, 1'b1);
        end
        for (int n = 13; n >= 2; n--) begin
            step(0, 1, '0, 0, "thr_drain");
            if (n == 13) chkb("thr.af_down13", afull_c, 1'b0);
            if (n == 3)  chkb("thr.ae_down3", aempty_c, 1'b0);
            if (n == 2)  chkb("thr.ae_down2", aempty_c, 1'b1);
        end
        step(0, 0, '0, 1, "clr3");

        // randomized traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 100; k++) begin
                int wp;
                wp = (ph % 2 == 0) ? 75 : 30;
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                     W'($urandom_range(0, 255)), $urandom_range(0, 59) == 0, "random");
            end
        end

        // asynchronous reset in the middle of a burst at count 7
        step(0, 0, '0, 1, "clr4");
        for (int i = 0; i < 7; i++) step(1, 0, W'(8'hC0 + i), 0, "burst");
        chkv("burst.count_c", 32'(count_c), 32'd7);
        we = 1'b1; d = 8'hEE;
        #1 rst = 1'b1;
        #1;
        model_step(0, 0, '0, 1);
        check_all("async_rst");
        chkv("async_rst.q_b", 32'(q_b), 32'h0);
        #1 rst = 1'b0; we = 1'b0;
        @(negedge clk);
        check_all("after_rst");
        step(1, 0, 8'h3C, 0, "post_rst_write");
        chkv("post_rst.q_b", 32'(q_b), 32'h3C);
        step(0, 1, '0, 0, "post_rst_read");
        chkv("post_rst.q_a", 32'(q_a), 32'h3C);
        chkv("post_rst.q_c", 32'(q_c), 32'h3C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
